// File: rtl/wb_trace_recorder_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_recorder_if
// Purpose  : Writeback sampling inputs and trace-record output port of the
//            writeback trace recorder, with CPU/consumer and recorder views.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_trace_recorder_if #(
  parameter int CNT_W = 16
) ();
  // Writeback activity sampled from the CPU
  logic             reg_write_enable;
  logic [4:0]       reg_write_addr;
  logic [31:0]      reg_write_data;
  logic             hilo_we;
  logic [31:0]      hi_i;
  logic [31:0]      lo_i;
  logic             record_skip;
  // Trace record stream
  logic             rec_valid;
  logic             rec_ready;
  logic [1:0]       rec_kind;
  logic [CNT_W-1:0] rec_index;
  logic [4:0]       rec_addr;
  logic [31:0]      rec_data0;
  logic [31:0]      rec_data1;

  modport master (
    output reg_write_enable, reg_write_addr, reg_write_data,
    output hilo_we, hi_i, lo_i, record_skip, rec_ready,
    input  rec_valid, rec_kind, rec_index, rec_addr, rec_data0, rec_data1
  );

  modport slave (
    input  reg_write_enable, reg_write_addr, reg_write_data,
    input  hilo_we, hi_i, lo_i, record_skip, rec_ready,
    output rec_valid, rec_kind, rec_index, rec_addr, rec_data0, rec_data1
  );
endinterface
`default_nettype wire

// File: rtl/wb_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_recorder
// Purpose  : Turns per-cycle GPR / HI-LO writeback activity into indexed
//            trace records queued in a small FIFO behind a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_trace_recorder #(
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int SKIP_START = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  wb_trace_recorder_if.slave         bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WARM_W = (SKIP_START > 0) ? $clog2(SKIP_START + 1) : 1;
  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [WARM_W-1:0] WARM_DONE  = WARM_W'(SKIP_START);

  logic [WARM_W-1:0] warm;
  logic [CNT_W-1:0]  idx_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Record storage, one array per field; contents need no reset because the
  // outputs are masked whenever the FIFO is empty.
  logic [1:0]        kind_mem  [DEPTH];
  logic [CNT_W-1:0]  index_mem [DEPTH];
  logic [4:0]        addr_mem  [DEPTH];
  logic [31:0]       d0_mem    [DEPTH];
  logic [31:0]       d1_mem    [DEPTH];

  logic [1:0]        cand_kind;
  logic [4:0]        cand_addr;
  logic [31:0]       cand_d0;
  logic [31:0]       cand_d1;
  logic [CNT_W-1:0]  cand_index;
  logic              active;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              drop;
  logic              head_valid;

  // Build this cycle's candidate record: GPR beats HI/LO, unused fields zero.
  always_comb begin
    cand_kind = 2'd0;
    cand_addr = 5'd0;
    cand_d0   = 32'd0;
    cand_d1   = 32'd0;
    if (bus.reg_write_enable) begin
      cand_kind = 2'd1;
      cand_addr = bus.reg_write_addr;
      cand_d0   = bus.reg_write_data;
    end else if (bus.hilo_we) begin
      cand_kind = 2'd2;
      cand_d0   = bus.hi_i;
      cand_d1   = bus.lo_i;
    end
  end

  assign active     = (warm == WARM_DONE);
  assign cand_index = idx_cnt + CNT_W'(1);
  assign head_valid = (level != '0);
  assign push_req   = active && ((cand_kind != 2'd0) || bus.record_skip);
  assign pop        = head_valid && bus.rec_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok    = push_req && ((level != FULL_LEVEL) || pop);
  assign drop       = push_req && !push_ok;

  // Warm-up/index counters, FIFO pointers, occupancy and overflow tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm       <= '0;
      idx_cnt    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      if (!active) begin
        warm <= warm + WARM_W'(1);
      end else begin
        idx_cnt <= cand_index;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level + LVL_W'(push_ok) - LVL_W'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  // Write accepted candidates into the slot behind the current tail.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      kind_mem[wr_ptr]  <= cand_kind;
      index_mem[wr_ptr] <= cand_index;
      addr_mem[wr_ptr]  <= cand_addr;
      d0_mem[wr_ptr]    <= cand_d0;
      d1_mem[wr_ptr]    <= cand_d1;
    end
  end

  assign bus.rec_valid = head_valid;
  assign bus.rec_kind  = head_valid ? kind_mem[rd_ptr]  : 2'd0;
  assign bus.rec_index = head_valid ? index_mem[rd_ptr] : '0;
  assign bus.rec_addr  = head_valid ? addr_mem[rd_ptr]  : 5'd0;
  assign bus.rec_data0 = head_valid ? d0_mem[rd_ptr]    : 32'd0;
  assign bus.rec_data1 = head_valid ? d1_mem[rd_ptr]    : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_trace_recorder
// Purpose  : Self-checking bench for wb_trace_recorder: queue-based reference
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_trace_recorder;

  localparam int DEPTH = 16;
  localparam int SKIP  = 5;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] idx;
    logic [4:0]  addr;
    logic [31:0] d0;
    logic [31:0] d1;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  wb_trace_recorder_if #(.CNT_W(16)) bus ();

  wb_trace_recorder #(.DEPTH(DEPTH), .CNT_W(16), .SKIP_START(SKIP)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  rec_t        mq[$];
  rec_t        alog[$];
  int          m_warm;
  logic [15:0] m_idx;
  logic        m_ovf;
  logic [15:0] m_drop;
  rec_t        m_r;
  bit          m_have;
  bit          m_pop;
  bit          m_ok;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_warm = 0;
      m_idx  = 16'd0;
      m_ovf  = 1'b0;
      m_drop = 16'd0;
    end else begin
      m_pop  = (mq.size() > 0) && bus.rec_ready;
      m_have = 1'b0;
      m_r    = '{kind: 2'd0, idx: 16'd0, addr: 5'd0, d0: 32'd0, d1: 32'd0};
      if (m_warm < SKIP) begin
        m_warm++;
      end else begin
        m_idx   = m_idx + 16'd1;
        m_r.idx = m_idx;
        if (bus.reg_write_enable) begin
          m_r.kind = 2'd1; m_r.addr = bus.reg_write_addr; m_r.d0 = bus.reg_write_data;
        end else if (bus.hilo_we) begin
          m_r.kind = 2'd2; m_r.d0 = bus.hi_i; m_r.d1 = bus.lo_i;
        end
        m_have = (m_r.kind != 2'd0) || bus.record_skip;
      end
      m_ok = m_have && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_ok) mq.push_back(m_r);
      else if (m_have) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
  end

  // ---------------- per-cycle compare and acceptance log ----------------
  always @(negedge clk) begin
    chk("valid",      64'(bus.rec_valid), 64'(mq.size() != 0));
    chk("level",      64'(level),         64'(mq.size()));
    chk("overflow",   64'(overflow),      64'(m_ovf));
    chk("drop_count", 64'(drop_count),    64'(m_drop));
    if (mq.size() != 0) begin
      chk("head_kind",  64'(bus.rec_kind),  64'(mq[0].kind));
      chk("head_index", 64'(bus.rec_index), 64'(mq[0].idx));
      chk("head_addr",  64'(bus.rec_addr),  64'(mq[0].addr));
      chk("head_data0", 64'(bus.rec_data0), 64'(mq[0].d0));
      chk("head_data1", 64'(bus.rec_data1), 64'(mq[0].d1));
    end
    if (!rst && bus.rec_valid && bus.rec_ready)
      alog.push_back('{kind: bus.rec_kind, idx: bus.rec_index, addr: bus.rec_addr,
                       d0: bus.rec_data0, d1: bus.rec_data1});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.reg_write_enable = 1'b0;
    bus.reg_write_addr   = 5'd0;
    bus.reg_write_data   = 32'd0;
    bus.hilo_we          = 1'b0;
    bus.hi_i             = 32'd0;
    bus.lo_i             = 32'd0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"},  64'(bus.rec_valid), 64'd0);
    chk({tag, "_kind"},   64'(bus.rec_kind),  64'd0);
    chk({tag, "_index"},  64'(bus.rec_index), 64'd0);
    chk({tag, "_addr"},   64'(bus.rec_addr),  64'd0);
    chk({tag, "_data0"},  64'(bus.rec_data0), 64'd0);
    chk({tag, "_data1"},  64'(bus.rec_data1), 64'd0);
    chk({tag, "_level"},  64'(level),         64'd0);
    chk({tag, "_ovf"},    64'(overflow),      64'd0);
    chk({tag, "_drops"},  64'(drop_count),    64'd0);
  endtask

  // One reset edge, then the warm-up window with idle writeback inputs.
  task automatic restart(input logic ready, input logic skip);
    idle_inputs();
    bus.rec_ready   = ready;
    bus.record_skip = skip;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (SKIP) step();
    alog.delete();
  endtask

  initial begin
    idle_inputs();
    bus.record_skip = 1'b0;
    bus.rec_ready   = 1'b0;
    rst = 1'b1;
    step();
    step();
    check_zero_outputs("reset");

    // Warm-up: only edges 6..8 yield (skip) records.
    rst = 1'b0;
    bus.record_skip = 1'b1;
    bus.rec_ready   = 1'b1;
    repeat (SKIP) step();
    chk("warmup_level", 64'(level), 64'd0);
    chk("warmup_valid", 64'(bus.rec_valid), 64'd0);
    repeat (3) step();
    bus.record_skip = 1'b0;
    repeat (3) step();
    chk("warmup_count", 64'(alog.size()), 64'd3);
    for (int k = 0; k < alog.size(); k++) begin
      chk("warmup_idx",  64'(alog[k].idx),  64'(k + 1));
      chk("warmup_kind", 64'(alog[k].kind), 64'd0);
    end

    // GPR vs HI/LO priority.
    restart(1'b0, 1'b0);
    bus.reg_write_enable = 1'b1; bus.reg_write_addr = 5'd3; bus.reg_write_data = 32'h0000_1234;
    bus.hilo_we = 1'b1; bus.hi_i = 32'hAAAA_AAAA; bus.lo_i = 32'h5555_5555;
    step();
    bus.reg_write_enable = 1'b0; bus.reg_write_addr = 5'd0; bus.reg_write_data = 32'd0;
    bus.hi_i = 32'hDEAD_BEEF; bus.lo_i = 32'h0000_0001;
    step();
    idle_inputs();
    bus.rec_ready = 1'b1;
    repeat (4) step();
    chk("prio_count", 64'(alog.size()), 64'd2);
    if (alog.size() == 2) begin
      chk("prio0_kind",  64'(alog[0].kind), 64'd1);
      chk("prio0_idx",   64'(alog[0].idx),  64'd1);
      chk("prio0_addr",  64'(alog[0].addr), 64'd3);
      chk("prio0_d0",    64'(alog[0].d0),   64'h0000_1234);
      chk("prio0_d1",    64'(alog[0].d1),   64'd0);
      chk("prio1_kind",  64'(alog[1].kind), 64'd2);
      chk("prio1_idx",   64'(alog[1].idx),  64'd2);
      chk("prio1_addr",  64'(alog[1].addr), 64'd0);
      chk("prio1_d0",    64'(alog[1].d0),   64'hDEAD_BEEF);
      chk("prio1_d1",    64'(alog[1].d1),   64'h0000_0001);
    end

    // Skip filtering: only indices 2 and 5 carry GPR writes.
    restart(1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      bus.reg_write_enable = (i == 2) || (i == 5);
      bus.reg_write_addr   = 5'(i);
      bus.reg_write_data   = 32'(i * 16);
      step();
    end
    idle_inputs();
    repeat (3) step();
    chk("filt_count", 64'(alog.size()), 64'd2);
    if (alog.size() == 2) begin
      chk("filt0_idx", 64'(alog[0].idx), 64'd2);
      chk("filt1_idx", 64'(alog[1].idx), 64'd5);
      chk("filt1_d0",  64'(alog[1].d0),  64'h50);
    end
    chk("filt_ovf", 64'(overflow), 64'd0);

    // Overflow: 20 GPR candidates into a stalled 16-entry FIFO.
    restart(1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      bus.reg_write_enable = 1'b1;
      bus.reg_write_addr   = 5'(i);
      bus.reg_write_data   = 32'h100 + 32'(i);
      step();
    end
    chk("ovf_level", 64'(level),      64'd16);
    chk("ovf_flag",  64'(overflow),   64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd4);

    // Full FIFO with a pop every edge: pushes keep succeeding.
    bus.rec_ready = 1'b1;
    for (int i = 21; i <= 26; i++) begin
      bus.reg_write_addr = 5'(i);
      bus.reg_write_data = 32'h100 + 32'(i);
      step();
      chk("full_pp_level", 64'(level), 64'd16);
    end
    chk("full_pp_drops", 64'(drop_count), 64'd4);

    // Partial drain down to seven entries.
    idle_inputs();
    repeat (9) step();
    chk("drain_level", 64'(level),       64'd7);
    chk("drain_ovf",   64'(overflow),    64'd1);
    chk("drain_count", 64'(alog.size()), 64'd15);
    for (int k = 0; k < alog.size(); k++) begin
      chk("drain_idx", 64'(alog[k].idx), 64'(k + 1));
      chk("drain_d0",  64'(alog[k].d0),  64'h100 + 64'(k + 1));
    end

    // Reset mid-stream with seven pending records.
    bus.rec_ready = 1'b0;
    rst = 1'b1;
    step();
    check_zero_outputs("midrst");
    rst = 1'b0;
    repeat (SKIP) step();
    chk("rewarm_level", 64'(level), 64'd0);
    bus.reg_write_enable = 1'b1; bus.reg_write_addr = 5'd7; bus.reg_write_data = 32'd77;
    step();
    idle_inputs();
    chk("rewarm_valid", 64'(bus.rec_valid), 64'd1);
    chk("rewarm_index", 64'(bus.rec_index), 64'd1);
    chk("rewarm_kind",  64'(bus.rec_kind),  64'd1);
    chk("rewarm_addr",  64'(bus.rec_addr),  64'd7);
    step();
    chk("rewarm_hold",  64'(bus.rec_index), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
